// File: rtl/arith_pkg.sv
// Shared op codes, FSM states and saturation helper for the sequential arithmetic unit.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_RUN = 2'b01,
    DIV_FIX = 2'b10
  } state_e;

  localparam int SAT_W = 64;

  // Signed MAX (neg=0) or MIN (neg=1) of a w-bit word; callers keep the low w bits.
  function automatic logic [SAT_W-1:0] sat_val(input logic neg, input int w);
    logic [SAT_W-1:0] max_v;
    max_v = {SAT_W{1'b1}} >> (SAT_W - w + 1);
    if (neg) begin
      sat_val = ~max_v;
    end else begin
      sat_val = max_v;
    end
  endfunction

endpackage

// File: rtl/seq_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, DATA_W iterations after start_i.
module seq_div_core #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              CLK_in,
  input  logic              RST_in,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [DATA_W:0]   trial_s;
  logic              last_s;

  // Shifted partial remainder minus divisor; the top bit is the borrow.
  assign trial_s = {rem_q, quo_q[DATA_W-1]} - {1'b0, div_q};
  assign last_s  = run_q & (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      div_d = divisor_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!trial_s[DATA_W]) begin
        rem_d = trial_s[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      run_d = ~last_s;
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = last_s;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Signed ADD/SUB/MUL in one cycle plus iterative DIV; sign handling, special cases and
// registered result/flag outputs live here, magnitude division in seq_div_core.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                  CLK_in,
  input  logic                  RST_in,
  input  logic [DATA_W-1:0]     A_in,
  input  logic [DATA_W-1:0]     B_in,
  input  logic [3:0]            alu_fun,
  input  logic                  arith_En,
  input  logic                  sat_mode,
  output logic                  arith_busy,
  output logic [2*DATA_W-1:0]   arith_out,
  output logic                  arith_flag,
  output logic                  over_flow,
  output logic                  div_zero
);

  localparam int OUT_W = 2 * DATA_W;
  localparam int MSB   = DATA_W - 1;
  localparam logic [DATA_W-1:0] SMAX = DATA_W'(sat_val(1'b0, DATA_W));
  localparam logic [DATA_W-1:0] SMIN = DATA_W'(sat_val(1'b1, DATA_W));

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              sat_q, sat_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              flag_q, flag_d, ovf_q, ovf_d, dz_q, dz_d, busy_q, busy_d;

  op_e               op_s;
  logic              accept_s, start_s, done_s, unused_s;
  logic [DATA_W-1:0] sum_s, dif_s, addsub_s, addsub_sat_s;
  logic              add_ovf_s, sub_ovf_s, addsub_ovf_s;
  logic [OUT_W-1:0]  a_ext_s, b_ext_s, prod_s;
  logic              mul_ovf_s;
  logic [DATA_W-1:0] abs_a_s, abs_b_s, quo_u_s, rem_u_s, quo_fix_s, rem_fix_s;
  logic              div_ovf_s;

  assign op_s     = op_e'(alu_fun[1:0]);
  assign unused_s = ^alu_fun[3:2];
  assign accept_s = arith_En & ~busy_q & (state_q == IDLE);

  // Overflow is judged on the true signed result, so SUB of MIN is covered too.
  assign sum_s        = A_in + B_in;
  assign dif_s        = A_in - B_in;
  assign add_ovf_s    = (A_in[MSB] == B_in[MSB]) & (sum_s[MSB] != A_in[MSB]);
  assign sub_ovf_s    = (A_in[MSB] != B_in[MSB]) & (dif_s[MSB] != A_in[MSB]);
  assign addsub_s     = (op_s == OP_SUB) ? dif_s : sum_s;
  assign addsub_ovf_s = (op_s == OP_SUB) ? sub_ovf_s : add_ovf_s;
  assign addsub_sat_s = (sat_mode & addsub_ovf_s) ? DATA_W'(sat_val(A_in[MSB], DATA_W)) : addsub_s;

  assign a_ext_s   = {{DATA_W{A_in[MSB]}}, A_in};
  assign b_ext_s   = {{DATA_W{B_in[MSB]}}, B_in};
  assign prod_s    = a_ext_s * b_ext_s;
  assign mul_ovf_s = ~((&prod_s[OUT_W-1:MSB]) | ~(|prod_s[OUT_W-1:MSB]));

  assign abs_a_s = A_in[MSB] ? -A_in : A_in;
  assign abs_b_s = B_in[MSB] ? -B_in : B_in;

  seq_div_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .CLK_in     (CLK_in),
    .RST_in     (RST_in),
    .start_i    (start_s),
    .dividend_i (abs_a_s),
    .divisor_i  (abs_b_s),
    .done_o     (done_s),
    .quo_o      (quo_u_s),
    .rem_o      (rem_u_s)
  );

  // |MIN|/1 already yields MIN unsigned; only the saturated case needs replacing.
  assign div_ovf_s = (a_q == SMIN) & (b_q == '1);
  assign quo_fix_s = div_ovf_s ? (sat_q ? SMAX : SMIN)
                               : ((a_q[MSB] ^ b_q[MSB]) ? -quo_u_s : quo_u_s);
  assign rem_fix_s = a_q[MSB] ? -rem_u_s : rem_u_s;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d   = A_in;
          b_d   = B_in;
          sat_d = sat_mode;
          case (op_s)
            OP_ADD, OP_SUB: begin
              flag_d = 1'b1;
              out_d  = {{DATA_W{addsub_sat_s[MSB]}}, addsub_sat_s};
              ovf_d  = addsub_ovf_s;
              dz_d   = 1'b0;
            end
            OP_MUL: begin
              flag_d = 1'b1;
              out_d  = prod_s;
              ovf_d  = mul_ovf_s;
              dz_d   = 1'b0;
            end
            OP_DIV: begin
              if (B_in == '0) begin
                flag_d = 1'b1;
                out_d  = {A_in, {DATA_W{1'b0}}};
                ovf_d  = 1'b0;
                dz_d   = 1'b1;
              end else begin
                start_s = 1'b1;
                state_d = DIV_RUN;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        if (done_s) begin
          state_d = DIV_FIX;
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_FIX: begin
        state_d = IDLE;
        flag_d  = 1'b1;
        out_d   = {rem_fix_s, quo_fix_s};
        ovf_d   = div_ovf_s;
        dz_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      out_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  assign arith_busy = busy_q;
  assign arith_out  = out_q;
  assign arith_flag = flag_q;
  assign over_flow  = ovf_q;
  assign div_zero   = dz_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit (DATA_W=16): directed cases plus random stimulus
// against an integer-arithmetic reference model compared every cycle.
module tb_seq_arith_unit;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [15:0] A_in, B_in;
  logic [3:0]  alu_fun;
  logic        arith_En, sat_mode;
  logic        arith_busy, arith_flag, over_flow, div_zero;
  logic [31:0] arith_out;

  int n_tests = 0;
  int n_fail  = 0;
  int flag_cnt = 0;

  seq_arith_unit #(.DATA_W(16)) dut (
    .CLK_in     (CLK),
    .RST_in     (rst_n),
    .A_in       (A_in),
    .B_in       (B_in),
    .alu_fun    (alu_fun),
    .arith_En   (arith_En),
    .sat_mode   (sat_mode),
    .arith_busy (arith_busy),
    .arith_out  (arith_out),
    .arith_flag (arith_flag),
    .over_flow  (over_flow),
    .div_zero   (div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {over_flow, div_zero, arith_out} from plain integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [1:0] op, input logic [15:0] a16,
                                         input logic [15:0] b16, input logic sat);
    int a, b, s, q, r;
    logic [15:0] w;
    logic [31:0] o;
    logic ovf, dz;
    a = int'($signed(a16));
    b = int'($signed(b16));
    ovf = 1'b0;
    dz  = 1'b0;
    o   = '0;
    case (op)
      ADD, SUB: begin
        s = (op == ADD) ? a + b : a - b;
        ovf = (s > 32767) || (s < -32768);
        if (ovf && sat) s = (a >= 0) ? 32767 : -32768;
        w = s[15:0];
        o = {{16{w[15]}}, w};
      end
      MUL: begin
        s = a * b;
        ovf = (s > 32767) || (s < -32768);
        o = s;
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          o = {a16, 16'h0000};
        end else if (a == -32768 && b == -1) begin
          ovf = 1'b1;
          q = sat ? 32767 : -32768;
          o = {16'h0000, q[15:0]};
        end else begin
          q = a / b;
          r = a % b;
          o = {r[15:0], q[15:0]};
        end
      end
    endcase
    return {ovf, dz, o};
  endfunction

  // Model state: expected outputs and cycles left until a pending DIV result appears.
  logic [33:0] m_res, m_pend;
  logic [31:0] m_out;
  logic        m_flag, m_busy, m_ovf, m_dz;
  int          m_left, m_acc;

  assign m_res = ref_op(alu_fun[1:0], A_in, B_in, sat_mode);

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= '0; m_flag <= 1'b0; m_busy <= 1'b0; m_ovf <= 1'b0; m_dz <= 1'b0;
      m_left <= 0; m_pend <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_flag <= 1'b1;
        m_busy <= 1'b0;
        {m_ovf, m_dz, m_out} <= m_pend;
      end else begin
        m_flag <= 1'b0;
      end
    end else if (arith_En) begin
      m_acc <= m_acc + 1;
      if (alu_fun[1:0] == DIV && B_in != 16'h0000) begin
        m_left <= 17;
        m_busy <= 1'b1;
        m_flag <= 1'b0;
        m_pend <= m_res;
      end else begin
        m_flag <= 1'b1;
        {m_ovf, m_dz, m_out} <= m_res;
      end
    end else begin
      m_flag <= 1'b0;
    end
  end

  initial m_acc = 0;

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      check("busy", 32'(arith_busy), 32'(m_busy));
      check("flag", 32'(arith_flag), 32'(m_flag));
      check("out", arith_out, m_out);
      check("over_flow", 32'(over_flow), 32'(m_ovf));
      check("div_zero", 32'(div_zero), 32'(m_dz));
      if (arith_flag === 1'b1) flag_cnt++;
    end
  end

  task automatic cyc(input logic en, input logic [1:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic sat);
    arith_En = en;
    alu_fun  = {2'b00, op};
    A_in     = a;
    B_in     = b;
    sat_mode = sat;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_flag(input int maxc, output int n);
    n = 0;
    while (arith_flag !== 1'b1 && n < maxc) begin
      cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
      n++;
    end
    check("flag_timeout", 32'(arith_flag), 32'd1);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int n, nb, acc0, flg0;
    logic [33:0] r;
    rst_n = 1'b0;
    arith_En = 1'b0; alu_fun = 4'h0; A_in = '0; B_in = '0; sat_mode = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out", arith_out, 32'h0);
    check("rst_busy", 32'(arith_busy), 32'd0);
    rst_n = 1'b1;

    // Hand-computed values that pin the reference model itself.
    r = ref_op(DIV, 16'hFFF9, 16'h0002, 1'b0);
    check("pin_div", r[31:0], 32'hFFFFFFFD);
    r = ref_op(MUL, 16'hFED4, 16'h00C8, 1'b0);
    check("pin_mul", {30'd0, r[33:32]}, 32'd2);
    r = ref_op(ADD, 16'h7FFF, 16'h0001, 1'b1);
    check("pin_add_sat", r[31:0], 32'h00007FFF);

    // Saturating and wrapping ADD overflow.
    cyc(1'b1, ADD, 16'h7FFF, 16'h0001, 1'b0);
    check("add_flag", 32'(arith_flag), 32'd1);
    check("add_wrap", arith_out, 32'hFFFF8000);
    check("add_ovf", 32'(over_flow), 32'd1);
    cyc(1'b1, ADD, 16'h7FFF, 16'h0001, 1'b1);
    check("add_sat", arith_out, 32'h00007FFF);

    // Back-to-back SUB then MUL.
    cyc(1'b1, SUB, 16'hFFFB, 16'h0007, 1'b0);
    check("sub_flag", 32'(arith_flag), 32'd1);
    check("sub_out", arith_out, 32'hFFFFFFF4);
    cyc(1'b1, MUL, 16'hFED4, 16'h00C8, 1'b0);
    check("mul_flag", 32'(arith_flag), 32'd1);
    check("mul_out", arith_out, 32'hFFFF15A0);
    check("mul_ovf", 32'(over_flow), 32'd1);
    cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);

    // DIV -7/2 with ignored requests while busy.
    cyc(1'b1, DIV, 16'hFFF9, 16'h0002, 1'b0);
    n = 0; nb = 0;
    while (arith_flag !== 1'b1 && n < 40) begin
      if (arith_busy === 1'b1) nb++;
      cyc(1'(n % 2), ADD, 16'h0001, 16'h0001, 1'b0);
      n++;
    end
    check("div_latency", 32'(n + 1), 32'd18);
    check("div_busy_cycles", 32'(nb), 32'd17);
    check("div_out", arith_out, 32'hFFFFFFFD);
    check("div_busy_at_flag", 32'(arith_busy), 32'd0);

    // MIN / -1, plain and saturated, then divide by zero.
    cyc(1'b1, DIV, 16'h8000, 16'hFFFF, 1'b0);
    wait_flag(40, n);
    check("minm1_out", arith_out, 32'h00008000);
    check("minm1_ovf", 32'(over_flow), 32'd1);
    cyc(1'b1, DIV, 16'h8000, 16'hFFFF, 1'b1);
    wait_flag(40, n);
    check("minm1_sat", arith_out, 32'h00007FFF);
    cyc(1'b1, DIV, 16'h007B, 16'h0000, 1'b0);
    check("dz_flag", 32'(arith_flag), 32'd1);
    check("dz_out", arith_out, 32'h007B0000);
    check("dz_bit", 32'(div_zero), 32'd1);
    check("dz_ovf", 32'(over_flow), 32'd0);

    // Reset in the middle of a DIV aborts it.
    cyc(1'b1, DIV, 16'h03E8, 16'h0003, 1'b0);
    repeat (7) cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_out", arith_out, 32'h0);
    check("abort_busy", 32'(arith_busy), 32'd0);
    repeat (2) cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
      if (arith_flag === 1'b1) nb++;
    end
    check("abort_no_flag", 32'(nb), 32'd0);
    cyc(1'b1, ADD, 16'h0001, 16'h0001, 1'b0);
    check("post_reset_add", arith_out, 32'h00000002);
    cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);

    // Random traffic; every accepted request must produce exactly one flag.
    acc0 = m_acc;
    flg0 = flag_cnt;
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd16(), rnd16(),
          1'($urandom_range(0, 1)));
    end
    repeat (25) cyc(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
    check("flag_count", 32'(flag_cnt - flg0), 32'(m_acc - acc0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
